muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the EX forwarding/ALU-source operand mux. It consumes the two forwarded operands for M-extension instructions and computes the 32-bit result over multiple cycles. It raises a stall request so the hazard logic holds IF/ID/EX and bubbles EX/MEM until the result is ready.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit_if.sv | 20 ++
 rtl/muldiv_unit_div_restoring_step.sv | 18 +
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, flush,
                  input  busy, stall_req, done, result);
  modport slave  (input  start, funct3, op_a, op_b, flush,
                  output busy, stall_req, done, result);

endinterface

// File: rtl/muldiv_unit_div_restoring_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_restoring_step
  import muldiv_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN-1:0] diff;

  // When the subtraction succeeds the true difference is below the divisor, so 32 bits hold it.
  assign q_bit   = (rem_in >= {1'b0, divisor});
  assign diff    = rem_in[XLEN-1:0] - divisor;
  assign rem_out = q_bit ? diff : rem_in[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        op;
  logic              neg_res;
  logic [DW-1:0]     mcand, acc;
  logic [XLEN-1:0]   mplier, divisor, rem, result;
  logic              busy, done;

  logic              accept_c, a_signed_c, b_signed_c, sign_a_c, sign_b_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic              div_zero_c, div_ovf_c, short_c, last_c, q_bit_c;
  logic [XLEN-1:0]   short_res_c, calc_res_c, rem_step_c, quot_c;
  logic [DW-1:0]     acc_step_c, prod_c;

  // Operand decode and magnitude conversion at acceptance
  assign accept_c   = (state == ST_IDLE) && bus.start && !bus.flush;
  assign a_signed_c = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                      (bus.funct3 == F3_MULHSU) || (bus.funct3 == F3_DIV) ||
                      (bus.funct3 == F3_REM);
  assign b_signed_c = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                      (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
  assign sign_a_c   = a_signed_c && bus.op_a[XLEN-1];
  assign sign_b_c   = b_signed_c && bus.op_b[XLEN-1];
  assign mag_a_c    = sign_a_c ? -bus.op_a : bus.op_a;
  assign mag_b_c    = sign_b_c ? -bus.op_b : bus.op_b;
  assign div_zero_c = bus.funct3[2] && (bus.op_b == '0);
  assign div_ovf_c  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                      (bus.op_a == INT_MIN) && (bus.op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0] fa_c, fb_c;
  logic [DW-1:0] fprod_c;

  assign fa_c    = {sign_a_c, bus.op_a};
  assign fb_c    = {sign_b_c, bus.op_b};
  assign fprod_c = DW'($signed(fa_c)) * DW'($signed(fb_c));
  assign short_c = div_zero_c || div_ovf_c || !bus.funct3[2];
`else
  assign short_c = div_zero_c || div_ovf_c;
`endif

  // Results that bypass the iterative datapath
  always_comb begin
    short_res_c = '0;
    case (bus.funct3)
      F3_DIV, F3_DIVU: short_res_c = div_zero_c ? '1 : bus.op_a;
      F3_REM, F3_REMU: short_res_c = div_zero_c ? bus.op_a : '0;
`ifdef MULDIV_FAST_MUL_EN
      F3_MUL:          short_res_c = fprod_c[XLEN-1:0];
      default:         short_res_c = fprod_c[DW-1:XLEN];
`else
      default:         short_res_c = '0;
`endif
    endcase
  end

  div_restoring_step u_div_step (
    .rem_in  ({rem, mplier[XLEN-1]}),
    .divisor (divisor),
    .rem_out (rem_step_c),
    .q_bit   (q_bit_c)
  );

  // Final-step values include this cycle's contribution, then the sign fix-up
  assign acc_step_c = acc + (mplier[0] ? mcand : '0);
  assign prod_c     = neg_res ? -acc_step_c : acc_step_c;
  assign quot_c     = {mplier[XLEN-2:0], q_bit_c};
  assign last_c     = (counter == CNT_W'(ITERS - 1));

  always_comb begin
    calc_res_c = '0;
    case (op)
      F3_MUL:                      calc_res_c = prod_c[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res_c = prod_c[DW-1:XLEN];
      F3_DIV, F3_DIVU:             calc_res_c = neg_res ? -quot_c : quot_c;
      default:                     calc_res_c = neg_res ? -rem_step_c : rem_step_c;
    endcase
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_c) state_nxt = short_c ? ST_DONE : ST_CALC;
      ST_CALC: if (last_c)   state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
    if (bus.flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state_nxt == ST_DONE);
      counter <= ((state == ST_CALC) && (state_nxt == ST_CALC)) ? counter + CNT_W'(1) : '0;
    end
  end

  // Datapath: mplier is the multiplier for MUL*, and dividend-then-quotient for DIV/REM
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
    end else if (accept_c) begin
      op      <= bus.funct3;
      neg_res <= (bus.funct3[2] && bus.funct3[1]) ? sign_a_c : (sign_a_c ^ sign_b_c);
      mcand   <= DW'(mag_a_c);
      mplier  <= bus.funct3[2] ? mag_a_c : mag_b_c;
      divisor <= mag_b_c;
      acc     <= '0;
      rem     <= '0;
      if (short_c) result <= short_res_c;
    end else if ((state == ST_CALC) && !bus.flush) begin
      mcand  <= mcand << 1;
      acc    <= acc_step_c;
      rem    <= rem_step_c;
      mplier <= op[2] ? quot_c : (mplier >> 1);
      if (last_c) result <= calc_res_c;
    end
  end

  assign bus.stall_req = !reset && (accept_c || (state == ST_CALC));
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus per-cycle output compare.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if mif ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_cnt = 0;
  int done_cnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Behavioural model: m_cnt = cycles since acceptance (0 = idle), done in cycle m_L
  int          m_cnt = 0;
  int          m_L   = 1;
  logic [31:0] m_exp = '0;
  logic [31:0] m_result = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_cnt = 0;
      m_result = '0;
      chk_en = 1'b1;
    end else if (mif.flush) begin
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (mif.start) begin
        m_L   = ref_lat(mif.funct3, mif.op_a, mif.op_b);
        m_exp = ref_result(mif.funct3, mif.op_a, mif.op_b);
        m_cnt = 1;
        if (m_L == 1) m_result = m_exp;
      end
    end else if (m_cnt == m_L) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == m_L) m_result = m_exp;
    end
  end

  // Compare every cycle, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(mif.busy), 32'(m_cnt != 0));
      check("done", 32'(mif.done), 32'(m_cnt != 0 && m_cnt == m_L));
      check("stall_req", 32'(mif.stall_req),
            32'(!reset && ((m_cnt == 0 && mif.start && !mif.flush) || (m_cnt != 0 && m_cnt < m_L))));
      check("result", mif.result, m_result);
      if (mif.stall_req) stall_cnt++;
      if (mif.done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op from IDLE, wait (bounded) for done, check result and latency
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int lat);
    int n;
    mif.start = 1'b1; mif.funct3 = f; mif.op_a = a; mif.op_b = b;
    tick();
    mif.start = 1'b0;
    n = 1;
    while (!mif.done && n < 60) begin
      tick();
      n++;
    end
    check({name, " result"}, mif.result, want);
    check({name, " latency"}, 32'(n), 32'(lat));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mif.start = 1'b1; mif.flush = 1'b0; mif.funct3 = 3'd0; mif.op_a = '0; mif.op_b = '0;
    repeat (3) tick();
    check("reset result", mif.result, 32'h0);
    check("reset busy", 32'(mif.busy), 32'h0);
    reset = 1'b0; mif.start = 1'b0;
    tick();

    check("model MUL", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model MULHSU", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("model DIV", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model REM", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    stall_cnt = 0;
    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    check("MUL stall cycles", 32'(stall_cnt), 32'(MUL_LAT));
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIVU by 0", 3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("REM by 0", 3'd6, 32'h1234, 32'h0, 32'h1234, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Flush at counter 10: cycle T+11 after acceptance
    done_cnt = 0;
    mif.start = 1'b1; mif.funct3 = 3'd5; mif.op_a = 32'd1000; mif.op_b = 32'd3;
    tick();
    mif.start = 1'b0;
    repeat (10) tick();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    check("flush busy", 32'(mif.busy), 32'h0);
    repeat (40) tick();
    check("flush no done", 32'(done_cnt), 32'h0);
    check("flush result kept", mif.result, 32'h8000_0000);
    run_op("after flush", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

    // start during CALC with other operands must be ignored
    mif.start = 1'b1; mif.funct3 = 3'd5; mif.op_a = 32'd100; mif.op_b = 32'd7;
    tick();
    repeat (4) tick();
    mif.funct3 = 3'd0; mif.op_a = 32'd3; mif.op_b = 32'd5;
    repeat (3) tick();
    mif.start = 1'b0;
    for (int n = 0; n < 40 && !mif.done; n++) tick();
    check("ignored start", mif.result, 32'd14);
    repeat (2) tick();

    // reset mid-CALC
    mif.start = 1'b1; mif.funct3 = 3'd3; mif.op_a = 32'hFFFF_FFFF; mif.op_b = 32'h2;
    tick();
    mif.start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset mid result", mif.result, 32'h0);
    check("reset mid busy", 32'(mif.busy), 32'h0);
    tick();

    // Randomized traffic, including zero divisors, overflow pairs, flushes and resets
    for (int i = 0; i < 3000; i++) begin
      mif.start  = ($urandom_range(0, 2) == 0);
      mif.funct3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin mif.op_a = $urandom; mif.op_b = 32'h0; end
        1: begin mif.op_a = 32'h8000_0000; mif.op_b = 32'hFFFF_FFFF; end
        2: begin mif.op_a = 32'($urandom_range(0, 300)); mif.op_b = 32'($urandom_range(1, 20)); end
        3: begin mif.op_a = $urandom; mif.op_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5)); end
        default: begin mif.op_a = $urandom; mif.op_b = $urandom; end
      endcase
      mif.flush = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      tick();
    end
    mif.start = 1'b0; mif.flush = 1'b0; reset = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
